fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded by reset.
REQ-002 Parameter PC_STEP, default 4, is the PC increment per sequential fetch.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF, is the instruction encoding that stops fetch.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 start  input  1: one-cycle pulse that begins fetching from the current PC.
REQ-007 redirect_valid  input  1: branch/jump redirect request.
REQ-008 redirect_pc  input  32: target PC, sampled when redirect_valid=1.
REQ-009 imem_addr  output  32: address to the combinational instruction memory; always equals the fetch PC.
REQ-010 imem_word  input  32: instruction returned combinationally for imem_addr.
REQ-011 inst_valid  output  1: queue head holds a valid instruction.
REQ-012 inst_ready  input  1: decode accepts the head this cycle.
REQ-013 inst_word  output  32: head instruction.
REQ-014 inst_pc  output  32: PC of the head instruction.
REQ-015 halted  output  1: high while in state HALTED.
REQ-016 fetch_count  output  16: number of instructions pushed since reset; wraps at 16'hFFFF->0.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and HALTED.
REQ-018 IDLE->RUN on start=1; RUN->HALTED on the cycle a word equal to HALT_WORD is pushed; HALTED->RUN on redirect_valid=1; start is ignored outside IDLE.
REQ-019 The 2-entry queue SHALL push {imem_word, PC} when state=RUN, count<2 and redirect_valid=0.
REQ-020 On push, PC SHALL become PC+PC_STEP (mod 2^32) and fetch_count SHALL increment by 1.
REQ-021 Pop SHALL occur when inst_valid=1 and inst_ready=1; push and pop in the same cycle SHALL both take effect (count unchanged).
REQ-022 Steady-state throughput SHALL be one instruction per cycle with inst_ready held high; latency from push to inst_valid SHALL be 1 cycle.
REQ-023 When count=2, push SHALL NOT occur and PC SHALL hold; no entry is ever overwritten.
REQ-024 redirect_valid=1 in RUN or HALTED SHALL flush the queue (count=0, inst_valid=0 next cycle), load PC=redirect_pc, suppress any push that cycle and discard a same-cycle pop.
REQ-025 redirect_valid=1 in IDLE SHALL load PC=redirect_pc and keep the state at IDLE.
REQ-026 The halt word SHALL itself be delivered to decode; queued entries ahead of it SHALL drain normally in HALTED.
REQ-027 inst_word and inst_pc SHALL hold their value while inst_valid=1 and inst_ready=0.
REQ-028 inst_word and inst_pc are don't-care when inst_valid=0.

Reset
REQ-029 On reset=1 at a clock edge: state=IDLE, PC=RESET_PC, count=0, inst_valid=0, halted=0, fetch_count=0.
REQ-030 Reset SHALL take priority over start, redirect, push and pop in the same cycle, including mid-operation.
REQ-031 imem_addr SHALL equal RESET_PC in the cycle after reset.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enumeration and the default values of RESET_PC, PC_STEP and HALT_WORD.
REQ-033 The queue SHALL be a sub-module fetch_queue: a 2-entry, 64-bit-wide FIFO with push, pop, flush, count, head output and synchronous reset.

Verification
REQ-034 Reset, start pulse, inst_ready=1, ROM words 0..3 = 0x11,0x22,0x33,0x44 -> inst_pc 0,4,8,12 with those words on consecutive cycles, starting 1 cycle after the first push.
REQ-035 inst_ready=0 for 5 cycles while in RUN -> count reaches 2; imem_addr holds at 8; after release, PCs 0,4,8 are delivered in order with no loss or duplication.
REQ-036 redirect_valid=1 with redirect_pc=0x40 while count=2 and a pop is in progress -> next cycle inst_valid=0 and imem_addr=0x40; the first instruction delivered afterwards has inst_pc=0x40.
REQ-037 HALT_WORD at address 0x8 -> state HALTED after it is pushed; the halt word is delivered with inst_pc=8; imem_addr holds at 0xC; fetch_count=3; redirect to 0x0 resumes RUN.
REQ-038 reset asserted mid-RUN with count=1 -> next cycle state=IDLE, inst_valid=0, PC=0, fetch_count=0; simultaneous start is ignored.
REQ-039 Preload 65535 pushes, then 1 more -> fetch_count wraps to 0; PC starting at 0xFFFF_FFFC increments to 0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   - fetch_state_e : controller FSM states
//   - fetch_entry_t : one queue entry, {instruction word, PC} (64 bits)
//   - DEF_*         : default values for the controller parameters
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP   = 32'd4;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0]  QUEUE_DEPTH   = 2'd2;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {word, pc} pairs.
// Ports:
//   clk, reset   : clock and synchronous active-high reset (control state only)
//   push         : write push_data (ignored when full or flushing)
//   pop          : drop the head entry (ignored when empty or flushing)
//   flush        : empty the queue; overrides push and pop in the same cycle
//   push_data    : entry to write
//   head         : oldest entry, meaningful only while valid=1
//   valid        : queue holds at least one entry
//   count        : number of stored entries (0..2)
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  fetch_entry_t entry_q [2];
  fetch_entry_t entry_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != QUEUE_DEPTH) && !flush;
    do_pop   = pop && (count_q != 2'd0) && !flush;

    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        entry_d[wr_ptr_q] = push_data;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign head  = entry_q[rd_ptr_q];
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks the PC through a combinational
// instruction memory, buffers fetched words in a 2-entry queue and hands
// them to decode with a valid/ready handshake.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   start           : pulse in IDLE to begin fetching from the current PC
//   redirect_valid  : load redirect_pc; flushes the queue outside IDLE
//   redirect_pc     : redirect target
//   imem_addr       : fetch PC presented to instruction memory
//   imem_word       : instruction at imem_addr (combinational)
//   inst_valid      : queue head is valid
//   inst_ready      : decode accepts the head this cycle
//   inst_word       : head instruction
//   inst_pc         : PC of the head instruction
//   halted          : controller is in HALTED
//   fetch_count     : instructions pushed since reset (wraps)
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] PC_STEP   = DEF_PC_STEP,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_word,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [15:0]  fetch_count_q, fetch_count_d;
  logic         halted_q, halted_d;

  logic         q_push, q_pop, q_flush, q_valid;
  logic [1:0]   q_count;
  fetch_entry_t q_head, q_push_data;

  // A redirect always wins over a push so the old path never enters the queue.
  assign q_push  = (state_q == ST_RUN) && (q_count != QUEUE_DEPTH) && !redirect_valid;
  assign q_flush = redirect_valid && (state_q != ST_IDLE);
  assign q_pop   = q_valid && inst_ready;

  assign q_push_data.word = imem_word;
  assign q_push_data.pc   = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (q_push && (imem_word == HALT_WORD)) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (redirect_valid) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (q_push) begin
      pc_d = pc_q + PC_STEP;
    end

    if (q_push) fetch_count_d = fetch_count_q + 16'd1;

    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      fetch_count_q <= 16'd0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      halted_q      <= halted_d;
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .pop       (q_pop),
    .flush     (q_flush),
    .push_data (q_push_data),
    .head      (q_head),
    .valid     (q_valid),
    .count     (q_count)
  );

  assign imem_addr   = pc_q;
  assign inst_valid  = q_valid;
  assign inst_word   = q_head.word;
  assign inst_pc     = q_head.pc;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_word;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic        halted;
  logic [15:0] fetch_count;
  logic        halt_en;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  fetch_controller dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_word      (imem_word),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: fixed words at 0..12, halt word at 8 when
  // enabled, otherwise addr+0x100 (never all-ones for word-aligned addresses).
  function automatic logic [31:0] rom(input logic [31:0] a, input logic he);
    if (he && a == 32'h8) return 32'hFFFF_FFFF;
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return a + 32'h100;
    endcase
  endfunction

  always_comb imem_word = rom(imem_addr, halt_en);

  typedef struct {
    logic        rst;
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        hen;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_word;
    logic [31:0] e_addr;
    logic        e_halted;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, st, rv, input logic [31:0] rpc,
                              input logic rdy, hen, ev, input logic [31:0] epc,
                              input logic [31:0] ew, ea, input logic eh,
                              input logic [15:0] efc);
    vec_t v;
    v.rst = rst; v.st = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.hen = hen;
    v.e_valid = ev; v.e_pc = epc; v.e_word = ew; v.e_addr = ea;
    v.e_halted = eh; v.e_fc = efc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input logic rst, st, rv, input logic [31:0] rpc, input logic rdy, hen);
    reset = rst; start = st; redirect_valid = rv; redirect_pc = rpc;
    inst_ready = rdy; halt_en = hen;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Sequential fetch, full throughput.
    vecs.push_back(mk(1,0,0,32'h0, 1,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,1,0,32'h0, 1,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 1,32'h0,32'h11,  32'h4,  0,16'd1));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 1,32'h4,32'h22,  32'h8,  0,16'd2));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 1,32'h8,32'h33,  32'hC,  0,16'd3));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 1,32'hC,32'h44,  32'h10, 0,16'd4));
    // Backpressure: queue fills, PC holds at 8, then drains in order.
    vecs.push_back(mk(1,0,0,32'h0, 0,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,1,0,32'h0, 0,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0, 0,0, 1,32'h0,32'h11,  32'h4,  0,16'd1));
    vecs.push_back(mk(0,0,0,32'h0, 0,0, 1,32'h0,32'h11,  32'h8,  0,16'd2));
    vecs.push_back(mk(0,0,0,32'h0, 0,0, 1,32'h0,32'h11,  32'h8,  0,16'd2));
    vecs.push_back(mk(0,0,0,32'h0, 0,0, 1,32'h0,32'h11,  32'h8,  0,16'd2));
    vecs.push_back(mk(0,0,0,32'h0, 0,0, 1,32'h0,32'h11,  32'h8,  0,16'd2));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 1,32'h4,32'h22,  32'h8,  0,16'd2));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 1,32'h8,32'h33,  32'hC,  0,16'd3));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 1,32'hC,32'h44,  32'h10, 0,16'd4));
    // Redirect while full with a pop in progress.
    vecs.push_back(mk(1,0,0,32'h0, 0,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,1,0,32'h0, 0,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0, 0,0, 1,32'h0,32'h11,  32'h4,  0,16'd1));
    vecs.push_back(mk(0,0,0,32'h0, 0,0, 1,32'h0,32'h11,  32'h8,  0,16'd2));
    vecs.push_back(mk(0,0,1,32'h40,1,0, 0,32'h0,32'h0,   32'h40, 0,16'd2));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 1,32'h40,32'h140,32'h44, 0,16'd3));
    // Halt word at 8, delivered, then redirect resumes.
    vecs.push_back(mk(1,0,0,32'h0, 1,1, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,1,0,32'h0, 1,1, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0, 1,1, 1,32'h0,32'h11,  32'h4,  0,16'd1));
    vecs.push_back(mk(0,0,0,32'h0, 1,1, 1,32'h4,32'h22,  32'h8,  0,16'd2));
    vecs.push_back(mk(0,0,0,32'h0, 1,1, 1,32'h8,32'hFFFF_FFFF,32'hC,1,16'd3));
    vecs.push_back(mk(0,0,0,32'h0, 1,1, 0,32'h0,32'h0,   32'hC,  1,16'd3));
    vecs.push_back(mk(0,1,0,32'h0, 1,1, 0,32'h0,32'h0,   32'hC,  1,16'd3));
    vecs.push_back(mk(0,0,1,32'h0, 1,1, 0,32'h0,32'h0,   32'h0,  0,16'd3));
    vecs.push_back(mk(0,0,0,32'h0, 1,1, 1,32'h0,32'h11,  32'h4,  0,16'd4));
    // Redirect in IDLE loads the PC but does not start fetching.
    vecs.push_back(mk(1,0,0,32'h0, 1,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,0,1,32'h20,1,0, 0,32'h0,32'h0,   32'h20, 0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 0,32'h0,32'h0,   32'h20, 0,16'd0));
    vecs.push_back(mk(0,1,0,32'h0, 1,0, 0,32'h0,32'h0,   32'h20, 0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 1,32'h20,32'h120,32'h24, 0,16'd1));
    // Reset mid-RUN with one entry queued; simultaneous start ignored.
    vecs.push_back(mk(1,0,0,32'h0, 0,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,1,0,32'h0, 0,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0, 0,0, 1,32'h0,32'h11,  32'h4,  0,16'd1));
    vecs.push_back(mk(1,1,0,32'h0, 1,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0, 1,0, 0,32'h0,32'h0,   32'h0,  0,16'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].hen);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
      chk($sformatf("v%0d fetch_count", i), {16'd0, fetch_count}, {16'd0, vecs[i].e_fc});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].e_pc);
        chk($sformatf("v%0d inst_word", i), inst_word, vecs[i].e_word);
      end
    end

    // Counter and PC wrap: start so that 65535 pushes land PC on 0xFFFF_FFFC.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'hFFFC_0000, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap fetch_count_ffff", {16'd0, fetch_count}, 32'h0000_FFFF);
    chk("wrap imem_addr_fffffffc", imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap fetch_count_0", {16'd0, fetch_count}, 32'h0);
    chk("wrap imem_addr_0", imem_addr, 32'h0);
    chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap inst_word", inst_word, 32'h0000_00FC);
    chk("wrap inst_valid", {31'd0, inst_valid}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
